onehot_decoder_drv: RTL and testbench

Sequential counterpart of the team's 16-to-4 one-hot encoder. Accepts a 4-bit index over a valid/ready handshake and drives the matching one-hot line on a registered 16-bit bus for a programmable number of cycles. It then forces one all-zero break cycle before accepting the next index. Used to strobe select/row lines that downstream logic reads back through the encoder.

---
 rtl/dec_pkg.sv | 16 +
 rtl/onehot_decoder_drv_if.sv | 32 +++
 rtl/onehot_to_bin.sv | 24 ++
 rtl/onehot_decoder_drv.sv | 126 ++++++++++++
 tb/tb_onehot_decoder_drv.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dec_pkg.sv
// Shared constants and FSM state encoding for the one-hot line driver.
// Consumed by onehot_decoder_drv, its interface and the onehot_to_bin checker.
package dec_pkg;

   localparam int DEC_IDX_W  = 4;
   localparam int DEC_HOLD_W = 8;
   localparam int DEC_OUT_W  = 2 ** DEC_IDX_W;
   localparam int ONEHOT_W   = DEC_OUT_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } dec_state_e;

endpackage

// File: rtl/onehot_decoder_drv_if.sv
// Request/strobe bundle of the one-hot line driver.
// master = index source, slave = driver block.
interface onehot_decoder_drv_if
   import dec_pkg::*;
#(
   parameter int IDX_W  = DEC_IDX_W,
   parameter int HOLD_W = DEC_HOLD_W
);

   localparam int OUT_W = 2 ** IDX_W;

   logic              enable;
   logic              in_valid;
   logic              in_ready;
   logic [IDX_W-1:0]  binary_in;
   logic [HOLD_W-1:0] hold_cycles;
   logic [OUT_W-1:0]  decoder_out;
   logic              out_valid;
   logic              done;
   logic              err;

   modport master (
      output enable, in_valid, binary_in, hold_cycles,
      input  in_ready, decoder_out, out_valid, done, err
   );

   modport slave (
      input  enable, in_valid, binary_in, hold_cycles,
      output in_ready, decoder_out, out_valid, done, err
   );

endinterface

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to index re-encoder with an exactly-one-bit flag.
// Used by the driver's self-check path only.
module onehot_to_bin
   import dec_pkg::*;
#(
   parameter int IDX_W = DEC_IDX_W
) (
   input  logic [2**IDX_W-1:0] onehot,
   output logic [IDX_W-1:0]    idx,
   output logic                is_onehot
);

   localparam int OUT_W = 2 ** IDX_W;

   always_comb begin
      idx = '0;
      for (int i = 0; i < OUT_W; i++) begin
         if (onehot[i]) idx = idx | IDX_W'(i);
      end
      is_onehot = (onehot != '0) &&
                  ((onehot & (onehot - OUT_W'(1))) == '0);
   end

endmodule

// File: rtl/onehot_decoder_drv.sv
// Drives one registered one-hot line for a programmable hold, then one break cycle.
// Optional runtime self-check of the output lines under DEC_SELFCHECK_EN.
module onehot_decoder_drv
   import dec_pkg::*;
#(
   parameter int IDX_W  = DEC_IDX_W,
   parameter int HOLD_W = DEC_HOLD_W
) (
   input logic clk,
   input logic rst_n,
   onehot_decoder_drv_if.slave bus
);

   localparam int OUT_W = 2 ** IDX_W;

   dec_state_e        state_q, state_d;
   logic [HOLD_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0]  dout_q, dout_d;
   logic              ov_q, ov_d;
   logic              done_q, done_d;
   logic              in_ready;
   logic              accept;

   assign in_ready = bus.enable && (state_q == IDLE);
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      ov_d    = ov_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = DRIVE;
               cnt_d   = (bus.hold_cycles == '0) ? HOLD_W'(1)
                                                 : bus.hold_cycles;
               dout_d  = OUT_W'(1) << bus.binary_in;
               ov_d    = 1'b1;
            end
         end
         DRIVE: begin
            // abort wins over a completion landing on the same edge
            if (!bus.enable || cnt_q <= HOLD_W'(1)) begin
               state_d = GAP;
               cnt_d   = '0;
               dout_d  = '0;
               ov_d    = 1'b0;
               done_d  = bus.enable;
            end else begin
               cnt_d = cnt_q - HOLD_W'(1);
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            dout_d  = '0;
            ov_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dout_q  <= '0;
         ov_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         ov_q    <= ov_d;
         done_q  <= done_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.decoder_out = dout_q;
   assign bus.out_valid   = ov_q;
   assign bus.done        = done_q;

`ifdef DEC_SELFCHECK_EN
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             err_q, err_d;
   logic [IDX_W-1:0] chk_idx;
   logic             chk_onehot;

   onehot_to_bin #(.IDX_W(IDX_W)) u_chk (
      .onehot    (dout_q),
      .idx       (chk_idx),
      .is_onehot (chk_onehot)
   );

   always_comb begin
      idx_d = idx_q;
      err_d = err_q;
      if (accept) idx_d = bus.binary_in;
      if (state_q == DRIVE) begin
         if (!chk_onehot || chk_idx != idx_q) err_d = 1'b1;
      end else if (dout_q != '0) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
         err_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         err_q <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_decoder_drv.sv
// Bench for onehot_decoder_drv: vector table plus burst scoreboard.
// Self-check section is compiled only when DEC_SELFCHECK_EN is defined.
module tb_onehot_decoder_drv;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;
   int   cyc;
   bit   mon_en;

   onehot_decoder_drv_if bus ();

   onehot_decoder_drv dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   typedef struct {
      logic [15:0] pat;
      int          len;
      bit          abort;
   } exp_t;

   typedef struct {
      logic [3:0]  idx;
      logic [7:0]  hold;
      logic [15:0] pat;
      int          len;
   } vec_t;

   exp_t sb[$];
   exp_t cur;
   bit   active;
   int   run_len;
   int   zeros;
   int   last_gap;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // burst monitor: pops one expectation per contiguous nonzero run
   always @(negedge clk) begin
      if (!rst_n) begin
         active = 1'b0;
         sb.delete();
         zeros  = 0;
      end else if (mon_en) begin
         chk("out_valid", 32'(bus.out_valid), 32'(bus.decoder_out != 0));
         chk("onehot", 32'($countones(bus.decoder_out) <= 1), 1);
         chk("err_clear", 32'(bus.err), 0);
         if (bus.decoder_out != 0) begin
            if (!active) begin
               last_gap = zeros;
               zeros    = 0;
               if (sb.size() == 0) begin
                  chk("unexpected_drive", 32'(bus.decoder_out), 0);
                  cur = '{16'h0, 0, 1'b0};
               end else begin
                  cur = sb.pop_front();
               end
               active  = 1'b1;
               run_len = 0;
            end
            run_len++;
            chk("pattern", 32'(bus.decoder_out), 32'(cur.pat));
         end else begin
            zeros++;
            if (active) begin
               active = 1'b0;
               chk("length", run_len, cur.len);
               chk("done_end", 32'(bus.done), 32'(!cur.abort));
            end else begin
               chk("done_idle", 32'(bus.done), 0);
            end
         end
      end
   end

   task automatic send(input logic [3:0] idx, input logic [7:0] hold,
                       input logic [15:0] pat, input int len,
                       input bit abort, input bit keep,
                       output int acc_cyc);
      bit got;
      got = 1'b0;
      acc_cyc = -1;
      bus.in_valid    = 1'b1;
      bus.binary_in   = idx;
      bus.hold_cycles = hold;
      for (int t = 0; t < 600 && !got; t++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            got = 1'b1;
            acc_cyc = cyc;
            sb.push_back('{pat, len, abort});
         end
         @(posedge clk);
         #1;
      end
      if (!keep) bus.in_valid = 1'b0;
      chk("accept", 32'(got), 1);
      if (got) chk("latency", 32'(bus.decoder_out), 32'(pat));
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 400; t++) begin
         if (sb.size() == 0 && !active) break;
         @(posedge clk);
         #1;
      end
      chk("drain", 32'(sb.size() == 0 && !active), 1);
   endtask

   vec_t vecs[8];
   int   a1, a2;

   initial begin
      vecs[0] = '{4'd3,  8'd4,   16'h0008, 4};
      vecs[1] = '{4'd0,  8'd0,   16'h0001, 1};
      vecs[2] = '{4'd15, 8'd255, 16'h8000, 255};
      vecs[3] = '{4'd5,  8'd1,   16'h0020, 1};
      vecs[4] = '{4'd9,  8'd2,   16'h0200, 2};
      vecs[5] = '{4'd12, 8'd7,   16'h1000, 7};
      vecs[6] = '{4'd1,  8'd3,   16'h0002, 3};
      vecs[7] = '{4'd14, 8'd10,  16'h4000, 10};

      n_pass = 0;
      n_total = 0;
      cyc = 0;
      mon_en = 1'b0;
      active = 1'b0;
      zeros = 0;
      last_gap = 0;
      rst_n = 1'b0;
      bus.enable = 1'b1;
      bus.in_valid = 1'b0;
      bus.binary_in = '0;
      bus.hold_cycles = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("por_dout", 32'(bus.decoder_out), 0);
      chk("por_ov", 32'(bus.out_valid), 0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      #1;

      // reset in the middle of a drive
      send(4'd5, 8'd50, 16'h0020, 50, 1'b0, 1'b0, a1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_dout", 32'(bus.decoder_out), 0);
      chk("rst_ov", 32'(bus.out_valid), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("rst_ready", 32'(bus.in_ready), 1);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_err", 32'(bus.err), 0);

      for (int i = 0; i < 8; i++) begin
         send(vecs[i].idx, vecs[i].hold, vecs[i].pat, vecs[i].len,
              1'b0, 1'b0, a1);
         wait_idle();
         chk("ready_after", 32'(bus.in_ready), 1);
      end

      // back-to-back with in_valid held high
      send(4'd7, 8'd3, 16'h0080, 3, 1'b0, 1'b1, a1);
      send(4'd8, 8'd3, 16'h0100, 3, 1'b0, 1'b0, a2);
      chk("b2b_spacing", a2 - a1, 5);
      wait_idle();
      chk("b2b_break", 32'(last_gap >= 1), 1);

      // abort on the 5th drive cycle
      send(4'd10, 8'd20, 16'h0400, 5, 1'b1, 1'b0, a1);
      repeat (4) @(posedge clk);
      #1;
      bus.enable = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_dout", 32'(bus.decoder_out), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("abort_noready", 32'(bus.in_ready), 0);
      bus.enable = 1'b1;
      #1;
      chk("abort_ready", 32'(bus.in_ready), 1);
      wait_idle();

      // in_valid pulses during DRIVE and GAP are ignored
      send(4'd2, 8'd6, 16'h0004, 6, 1'b0, 1'b0, a1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.binary_in = 4'd4;
      chk("drv_noready", 32'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("drv_hold", 32'(bus.decoder_out), 32'h0004);
      repeat (4) @(posedge clk);
      #1;
      chk("gap_zero", 32'(bus.decoder_out), 0);
      chk("gap_done", 32'(bus.done), 1);
      bus.in_valid = 1'b1;
      bus.binary_in = 4'd9;
      chk("gap_noready", 32'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("gap_ignored", 32'(bus.decoder_out), 0);
      end

      // enable low in IDLE blocks acceptance
      bus.enable = 1'b0;
      bus.in_valid = 1'b1;
      bus.binary_in = 4'd6;
      #1;
      chk("dis_noready", 32'(bus.in_ready), 0);
      repeat (4) begin
         @(posedge clk);
         #1;
         chk("dis_dout", 32'(bus.decoder_out), 0);
      end
      bus.in_valid = 1'b0;
      bus.enable = 1'b1;
      repeat (2) @(posedge clk);
      #1;

`ifdef DEC_SELFCHECK_EN
      for (int i = 0; i < 16; i++) begin
         send(4'(i), 8'd1, 16'h0001 << i, 1, 1'b0, 1'b0, a1);
         wait_idle();
      end
      chk("sweep_err", 32'(bus.err), 0);
      mon_en = 1'b0;
      force dut.dout_q = 16'h0003;
      repeat (2) @(posedge clk);
      #1;
      chk("force_err", 32'(bus.err), 1);
      release dut.dout_q;
      repeat (3) @(posedge clk);
      #1;
      chk("sticky_err", 32'(bus.err), 1);
      rst_n = 1'b0;
      #1;
      chk("err_reset", 32'(bus.err), 0);
      chk("err_reset_dout", 32'(bus.decoder_out), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
